tick_feed_sequencer: RTL and testbench

Parametrised market-data replay source that replaces the fixed 60-cycle ROM stepper in front of the TLU. On every programmable tick it reads one row of NUM_CH price samples from an external synchronous ROM and emits them channel by channel on a valid/ready stream. It adds start/stop control, backpressure, overrun accounting and end-of-data handling. It sits between the ROM (or a future feed interface) and one TLU instance per channel.

---
 rtl/tick_feed_pkg.sv | 17 +
 rtl/tick_interval_timer.sv | 38 +++
 rtl/tick_feed_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_tick_feed_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_feed_pkg.sv
// Shared types for the tick feed sequencer: FSM state encoding and channel-index width helper.
package tick_feed_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StFetch,
        StLoad,
        StPresent
    } state_e;

    // A single-channel build still carries a 1-bit channel field.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/tick_interval_timer.sv
// Free-running tick generator: counts 0..interval and pulses tick on the terminal count.
module tick_interval_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [Width-1:0] interval_i,
    output logic             tick_o
);

    logic [Width-1:0] count_q, count_d;
    logic [Width-1:0] interval_q, interval_d;

    always_comb begin
        tick_o     = en_i && (count_q == interval_q);
        count_d    = count_q;
        interval_d = interval_q;
        if (load_i) begin
            count_d    = '0;
            interval_d = interval_i;
        end else if (en_i) begin
            count_d = tick_o ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            interval_q <= '0;
        end else begin
            count_q    <= count_d;
            interval_q <= interval_d;
        end
    end

endmodule

// File: rtl/tick_feed_sequencer.sv
// Tick-paced ROM replay source streaming one row of NUM_CH samples per tick over valid/ready.
// Define TICK_FEED_LOOP_EN to wrap to row 0 after the last row instead of stopping with done.
module tick_feed_sequencer
    import tick_feed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned IDX_WIDTH      = 10,
    parameter int unsigned INTERVAL_WIDTH = 16,
    parameter int unsigned OVR_WIDTH      = 8,
    localparam int unsigned CH_W          = ch_width(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [INTERVAL_WIDTH-1:0] interval,
    output logic [IDX_WIDTH+CH_W-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CH_W-1:0]           out_ch,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic [OVR_WIDTH-1:0]      overrun_cnt
);

    localparam int unsigned SUM_W = IDX_WIDTH + 2;

    state_e                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    row_q, row_d;
    logic [IDX_WIDTH-1:0]    skip_q, skip_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic                    stop_pend_q, stop_pend_d;
    logic                    done_q, done_d;
    logic [OVR_WIDTH-1:0]    ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CH_W-1:0]         och_q, och_d;
    logic                    last_q, last_d;

    logic                    tick, timer_en, start_acc, drop, stop_eff, hs, last_ch, end_of_data;
    logic [SUM_W-1:0]        row_sum;
    logic [IDX_WIDTH-1:0]    row_next;

    assign timer_en  = (state_q != StIdle);
    assign start_acc = (state_q == StIdle) && start && !stop;
    assign drop      = tick && (state_q != StWait);
    assign stop_eff  = stop || stop_pend_q;
    assign hs        = (state_q == StPresent) && out_ready;
    assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));

    // Each tick dropped during the burst pushes the next row one further ahead.
    assign row_sum = SUM_W'(row_q) + SUM_W'(skip_q) + SUM_W'(1) + SUM_W'(drop);

`ifdef TICK_FEED_LOOP_EN
    assign end_of_data = 1'b0;
    assign row_next    = row_sum[IDX_WIDTH-1:0];
`else
    assign end_of_data = &row_q;
    assign row_next    = (row_sum >= SUM_W'(2**IDX_WIDTH - 1)) ? {IDX_WIDTH{1'b1}}
                                                               : row_sum[IDX_WIDTH-1:0];
`endif

    tick_interval_timer #(
        .Width (INTERVAL_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (timer_en),
        .load_i     (start_acc),
        .interval_i (interval),
        .tick_o     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start && !stop) state_d = StWait;
            StWait: begin
                if (stop_eff)  state_d = StIdle;
                else if (tick) state_d = StFetch;
            end
            StFetch:   state_d = stop_eff ? StIdle : StLoad;
            StLoad:    state_d = stop_eff ? StIdle : StPresent;
            StPresent: begin
                // Stop is honoured only at a handshake so a presented sample is never withdrawn.
                if (out_ready) begin
                    if (!last_ch)                     state_d = stop_eff ? StIdle : StFetch;
                    else if (end_of_data || stop_eff) state_d = StIdle;
                    else                              state_d = StWait;
                end
            end
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid   = (state_q == StPresent);
        busy        = (state_q != StIdle);
        rom_addr    = {row_q, ch_q};
        out_data    = data_q;
        out_ch      = och_q;
        out_last    = last_q;
        done        = done_q;
        overrun_cnt = ovr_q;
    end

    always_comb begin
        row_d       = row_q;
        skip_d      = skip_q;
        ch_d        = ch_q;
        stop_pend_d = stop_pend_q;
        done_d      = done_q;
        ovr_d       = ovr_q;
        data_d      = data_q;
        och_d       = och_q;
        last_d      = last_q;
        if (state_q == StIdle) begin
            stop_pend_d = 1'b0;
            if (start_acc) begin
                row_d  = '0;
                skip_d = '0;
                ch_d   = '0;
                done_d = 1'b0;
            end
        end else begin
            if (stop) stop_pend_d = 1'b1;
            if (drop) begin
                if (!(&ovr_q))  ovr_d  = ovr_q + OVR_WIDTH'(1);
                if (!(&skip_q)) skip_d = skip_q + IDX_WIDTH'(1);
            end
            if ((state_q == StWait) && tick) ch_d = '0;
            if (state_q == StLoad) begin
                data_d = rom_data;
                och_d  = ch_q;
                last_d = last_ch;
            end
            if (hs) begin
                if (!last_ch) begin
                    ch_d = ch_q + CH_W'(1);
                end else begin
                    ch_d   = '0;
                    skip_d = '0;
                    row_d  = row_next;
                    if (end_of_data) done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q       <= '0;
            skip_q      <= '0;
            ch_q        <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= '0;
            data_q      <= '0;
            och_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            row_q       <= row_d;
            skip_q      <= skip_d;
            ch_q        <= ch_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
            data_q      <= data_d;
            och_q       <= och_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_tick_feed_sequencer.sv
// Scoreboard bench for tick_feed_sequencer with an 8-row ROM; follows TICK_FEED_LOOP_EN if defined.
module tb_tick_feed_sequencer;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int IW = 3;
    localparam int CW = 2;
    localparam int AW = IW + CW;
    localparam int OW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ch;
        logic          last;
    } exp_t;

    logic          clk, rst, start, stop, out_ready;
    logic [15:0]   interval;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          out_valid, out_last, busy, done;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ch;
    logic [OW-1:0] overrun_cnt;

    int   checks, errors, hs_cnt, cyc;
    int   hs_times[$];
    exp_t exp_q[$];
    exp_t mon_e;

    tick_feed_sequencer #(
        .DATA_WIDTH     (DW),
        .NUM_CH         (NC),
        .IDX_WIDTH      (IW),
        .INTERVAL_WIDTH (16),
        .OVR_WIDTH      (OW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .interval    (interval),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .overrun_cnt (overrun_cnt)
    );

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return 16'h3C00 ^ (16'(a) * 16'd263);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    // Scoreboard: every handshake pops one expected sample.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cnt = hs_cnt + 1;
            hs_times.push_back(cyc);
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected: got data %h ch %0d last %0b, required no sample",
                         out_data, out_ch, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_data, out_ch, out_last} !== mon_e) begin
                    errors = errors + 1;
                    $display("FAIL sb_sample: got data %h ch %0d last %0b, required %h ch %0d last %0b",
                             out_data, out_ch, out_last, mon_e.data, mon_e.ch, mon_e.last);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input int row, input int ch);
        exp_t e;
        logic [AW-1:0] a;
        a = AW'(row * NC + ch);
        e.data = rom_fn(a);
        e.ch   = CW'(ch);
        e.last = (ch == NC - 1);
        exp_q.push_back(e);
    endtask

    task automatic push_row(input int row);
        for (int c = 0; c < NC; c++) push_exp(row, c);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1; interval = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        hs_times.delete();
    endtask

    task automatic pulse_start(input logic [15:0] iv);
        @(posedge clk); #1 interval = iv; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_hs(input int n, input int budget, output int got);
        int base, k;
        base = hs_cnt; k = 0;
        while ((hs_cnt - base) < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        got = hs_cnt - base;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1; interval = '0;
        @(negedge clk);
        checks += 2;
        if ({out_valid, out_ch, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid %0b ch %0d last %0b busy %0b done %0b, required all 0",
                     out_valid, out_ch, out_last, busy, done);
        end
        if ({out_data, rom_addr, overrun_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data: got data %h addr %h ovr %0d, required all 0",
                     out_data, rom_addr, overrun_cnt);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int lat, got;
        int gap_exp[7] = '{3, 3, 3, 4, 3, 3, 3};
        out_ready = 1'b1;
        hs_times.delete();
        push_row(0);
        push_row(1);
        pulse_start(16'd12);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, required 16", lat);
        end
        wait_hs(8, 100, got);
        checks++;
        if (got !== 8) begin
            errors++;
            $display("FAIL basic_count: got %0d handshakes, required 8", got);
        end
        if (hs_times.size() >= 8) begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (hs_times[i+1] - hs_times[i] !== gap_exp[i]) begin
                    errors++;
                    $display("FAIL basic_gap%0d: got %0d cycles, required %0d",
                             i, hs_times[i+1] - hs_times[i], gap_exp[i]);
                end
            end
        end
        pulse_stop();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_stop: got busy %0b, required 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int k, got;
        logic [DW-1:0] d0;
        logic [CW-1:0] c0;
        logic [AW-1:0] a0;
        out_ready = 1'b0;
        push_row(0);
        pulse_start(16'd12);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_ch !== '0) begin
            errors++;
            $display("FAIL bp_first: got valid %0b ch %0d, required valid 1 ch 0", out_valid, out_ch);
        end
        d0 = out_data; c0 = out_ch; a0 = rom_addr;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_data, out_ch, rom_addr} !== {1'b1, d0, c0, a0}) begin
                errors++;
                $display("FAIL bp_hold: got valid %0b data %h ch %0d addr %h, required 1 %h %0d %h",
                         out_valid, out_data, out_ch, rom_addr, d0, c0, a0);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_hs(4, 100, got);
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL bp_count: got %0d handshakes, required 4", got);
        end
        // The row is complete, so the sequencer now sits in WAIT.
        @(posedge clk); #1 stop = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_busy: got busy %0b, required 1", busy);
        end
        @(posedge clk); #1 stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_stop: got busy %0b, required 0", busy);
        end
    endtask

    task automatic test_stop_present();
        int k;
        out_ready = 1'b0;
        push_exp(0, 0);
        pulse_start(16'd12);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        pulse_stop();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({out_valid, busy} !== 2'b11) begin
                errors++;
                $display("FAIL stop_hold: got valid %0b busy %0b, required 1 1", out_valid, busy);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy} !== 2'b00 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stop_after_hs: got valid %0b busy %0b pending %0d, required 0 0 0",
                     out_valid, busy, exp_q.size());
        end
    endtask

    task automatic test_end_of_data();
        int got;
        out_ready = 1'b1;
        for (int r = 0; r < 2**IW; r++) push_row(r);
        pulse_start(16'd12);
        checks++;
        if ({rom_addr, done, busy} !== {AW'(0), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL eod_begin: got addr %h done %0b busy %0b, required 0 0 1",
                     rom_addr, done, busy);
        end
        wait_hs(4 * 2**IW, 600, got);
        checks++;
        if (got !== 4 * 2**IW) begin
            errors++;
            $display("FAIL eod_count: got %0d handshakes, required %0d", got, 4 * 2**IW);
        end
`ifdef TICK_FEED_LOOP_EN
        push_exp(0, 0);
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL eod_loop: got busy %0b done %0b, required 1 0", busy, done);
        end
        wait_hs(1, 100, got);
        checks++;
        if (got !== 1) begin
            errors++;
            $display("FAIL eod_wrap: got %0d handshakes, required 1", got);
        end
        pulse_stop();
`else
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL eod_done: got busy %0b done %0b, required 0 1", busy, done);
        end
        push_row(0);
        pulse_start(16'd12);
        checks++;
        if ({rom_addr, done, busy} !== {AW'(0), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL eod_restart: got addr %h done %0b busy %0b, required 0 0 1",
                     rom_addr, done, busy);
        end
        wait_hs(4, 100, got);
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL eod_restart_count: got %0d handshakes, required 4", got);
        end
        pulse_stop();
`endif
    endtask

    task automatic test_overrun();
        int got, exp_ovr;
        do_reset();
        out_ready = 1'b1;
        // Ticks every 3 cycles against a 12-cycle burst: 4 drops per row, row advances by 5.
        for (int run = 1; run <= 22; run++) begin
            push_row(0);
            push_row(5);
`ifdef TICK_FEED_LOOP_EN
            push_row(2);
`else
            push_row(7);
`endif
            pulse_start(16'd2);
            wait_hs(12, 200, got);
            stop = 1'b1;
            @(posedge clk); #1 stop = 1'b0;
            exp_ovr = (12 * run > 255) ? 255 : 12 * run;
            checks++;
            if (got !== 12 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ovr_run%0d: got %0d handshakes busy %0b, required 12 0", run, got, busy);
            end
            checks++;
            if (overrun_cnt !== OW'(exp_ovr)) begin
                errors++;
                $display("FAIL ovr_cnt%0d: got %0d, required %0d", run, overrun_cnt, exp_ovr);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int got;
        out_ready = 1'b1;
        pulse_start(16'd12);
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if ({busy, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL load_state: got busy %0b valid %0b, required 1 0", busy, out_valid);
        end
        rst = 1'b1;
        #1;
        checks += 2;
        if ({out_valid, out_ch, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: got valid %0b ch %0d last %0b busy %0b done %0b, required 0",
                     out_valid, out_ch, out_last, busy, done);
        end
        if ({out_data, rom_addr, overrun_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_mid_data: got data %h addr %h ovr %0d, required all 0",
                     out_data, rom_addr, overrun_cnt);
        end
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        push_row(0);
        pulse_start(16'd12);
        wait_hs(4, 100, got);
        checks++;
        if (got !== 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_resume: got %0d handshakes %0d pending, required 4 0",
                     got, exp_q.size());
        end
        pulse_stop();
    endtask

    initial begin
        checks = 0; errors = 0; hs_cnt = 0; cyc = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stop_present();
        test_end_of_data();
        test_overrun();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
